// File: rtl/ltcprop.sv
// FHP lattice-gas propagation stage: streams rows of eight hex cells and moves each particle one site.
// Optional LTCPROP_BOUNCE_EN reflects particles at the top and bottom frame edges instead of dropping them.
module ltcprop #(
    parameter int ROWS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last
);

    localparam int CW = $clog2(ROWS);
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

    typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0] prev_q, prev_d;
    logic [63:0] cur_q, cur_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_data_q, out_data_d;
    logic        out_last_q, out_last_d;

    logic [CW-1:0] emit_row;
    logic        at_top;
    logic        at_bottom;
    logic [63:0] prev_src;
    logic [63:0] next_src;
    logic [63:0] prop;
    logic        accept;
    logic        load;

    // Gather form of the hex move: odd rows sit half a cell right, so diagonals shift by parity.
    function automatic logic [63:0] propagate(input logic [63:0] prev_row,
                                              input logic [63:0] cur_row,
                                              input logic [63:0] next_row,
                                              input logic        odd);
        logic [63:0] res;
        int cm;
        int cp;
        res = '0;
        for (int c = 0; c < 8; c++) begin
            cm = (c + 7) % 8;
            cp = (c + 1) % 8;
            res[8*c+0] = cur_row[8*cm+0];
            res[8*c+3] = cur_row[8*cp+3];
            res[8*c+6] = cur_row[8*c+6];
            res[8*c+7] = cur_row[8*c+7];
            if (odd) begin
                res[8*c+1] = next_row[8*c+1];
                res[8*c+2] = next_row[8*cp+2];
                res[8*c+4] = prev_row[8*cp+4];
                res[8*c+5] = prev_row[8*c+5];
            end else begin
                res[8*c+1] = next_row[8*cm+1];
                res[8*c+2] = next_row[8*c+2];
                res[8*c+4] = prev_row[8*c+4];
                res[8*c+5] = prev_row[8*cm+5];
            end
        end
        return res;
    endfunction

    always_comb begin
        emit_row  = (state_q == DRAIN) ? LAST_ROW : (cnt_q - CW'(1));
        at_top    = (state_q != DRAIN) && (emit_row == '0);
        at_bottom = (state_q == DRAIN);
        prev_src  = at_top ? '0 : prev_q;
        next_src  = at_bottom ? '0 : in_data;
        prop      = propagate(prev_src, cur_q, next_src, emit_row[0]);
`ifdef LTCPROP_BOUNCE_EN
        for (int c = 0; c < 8; c++) begin
            if (at_top) begin
                prop[8*c+4] = cur_q[8*c+1];
                prop[8*c+5] = cur_q[8*c+2];
            end
            if (at_bottom) begin
                prop[8*c+1] = cur_q[8*c+4];
                prop[8*c+2] = cur_q[8*c+5];
            end
        end
`endif
    end

    // in_ready is combinational on out_ready so a consumed output can be refilled in the same cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        load        = 1'b0;

        case (state_q)
            FILL:    in_ready = 1'b1;
            RUN:     in_ready = !out_valid_q || out_ready;
            default: in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (accept) begin
                    cur_d   = in_data;
                    prev_d  = '0;
                    cnt_d   = CW'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    load   = 1'b1;
                    prev_d = cur_q;
                    cur_d  = in_data;
                    if (cnt_q == LAST_ROW) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = prop;
            out_last_d  = at_bottom;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            prev_q      <= '0;
            cur_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_ltcprop.sv
// Scoreboard bench for ltcprop: a particle-scatter reference model predicts each frame,
// a monitor pops and compares whenever an output row is handed over.
module tb_ltcprop;

    localparam int ROWS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;

    always #5 clk = ~clk;

    ltcprop #(.ROWS(ROWS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          ready_mode = 0;
    int          got_idx = 0;
    logic [64:0] exp_q[$];
    logic [63:0] in_frame[ROWS];
    logic [63:0] exp_frame[ROWS];
    logic [63:0] got_rows[ROWS];

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Scatter model: every particle is sent to its neighbour site on the offset hex grid.
    function automatic void modelFrame();
        int odd, dr, dc, nr, nc, nd;
        for (int r = 0; r < ROWS; r++) exp_frame[r] = '0;
        for (int r = 0; r < ROWS; r++) begin
            odd = r % 2;
            for (int c = 0; c < 8; c++) begin
                exp_frame[r][8*c+6] = in_frame[r][8*c+6];
                exp_frame[r][8*c+7] = in_frame[r][8*c+7];
                for (int d = 0; d < 6; d++) begin
                    if (in_frame[r][8*c+d]) begin
                        case (d)
                            0: begin dr = 0;  dc = 1;       end
                            1: begin dr = -1; dc = odd;     end
                            2: begin dr = -1; dc = odd - 1; end
                            3: begin dr = 0;  dc = -1;      end
                            4: begin dr = 1;  dc = odd - 1; end
                            default: begin dr = 1; dc = odd; end
                        endcase
                        nr = r + dr;
                        nc = (c + dc + 8) % 8;
                        nd = d;
                        if (nr < 0 || nr >= ROWS) begin
`ifdef LTCPROP_BOUNCE_EN
                            nd = (d == 1) ? 4 : (d == 2) ? 5 : (d == 4) ? 1 : 2;
                            exp_frame[r][8*c+nd] = 1'b1;
`endif
                        end else begin
                            exp_frame[nr][8*nc+nd] = 1'b1;
                        end
                    end
                end
            end
        end
    endfunction

    task automatic clearFrame();
        for (int r = 0; r < ROWS; r++) in_frame[r] = '0;
    endtask

    task automatic randomFrame();
        for (int r = 0; r < ROWS; r++) in_frame[r] = {$urandom, $urandom};
    endtask

    // Pushes the predicted frame, then offers the first nrows rows with a bounded handshake wait.
    task automatic applyStimulus(input int nrows);
        int cyc;
        modelFrame();
        for (int r = 0; r < ROWS; r++) exp_q.push_back({(r == ROWS - 1), exp_frame[r]});
        for (int i = 0; i < nrows; i++) begin
            in_valid = 1'b1;
            in_data  = in_frame[i];
            cyc = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                cyc++;
                if (cyc > 100) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL in_handshake_timeout: row %0d never accepted, required in_ready=1", i);
                    in_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic waitIdle();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: %0d rows outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic monitor();
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_output: got %h, expected no row", out_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", out_data, e[63:0]);
                    checkOutput("out_last", {63'b0, out_last}, {63'b0, e[64]});
                end
                got_rows[got_idx] = out_data;
                got_idx = (got_idx + 1) % ROWS;
            end
        end
    endtask

    task automatic readyDriver();
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom % 4) != 0;
                default: out_ready = 1'b0;
            endcase
        end
    endtask

    task automatic stallCheck();
        logic [63:0] d0;
        int cyc = 0;
        @(negedge clk);
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("stall_out_valid", {63'b0, out_valid}, 64'd1);
        d0 = out_data;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_in_ready", {63'b0, in_ready}, 64'd0);
            checkOutput("stall_out_data", out_data, d0);
        end
        @(posedge clk); #1;
        ready_mode = 0;
    endtask

    initial begin
        int sum_in;
        int sum_out;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        fork
            monitor();
            readyDriver();
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("reset_out_data", out_data, 64'd0);
        checkOutput("reset_out_last", {63'b0, out_last}, 64'd0);
        checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk); #1;

        $display("[TB] directed frames");
        clearFrame(); in_frame[0] = 64'h01 << 56;
        applyStimulus(ROWS); waitIdle();
        for (int r = 0; r < ROWS; r++)
            checkOutput($sformatf("wrap_row%0d", r), got_rows[r], (r == 0) ? 64'h01 : 64'h0);

        clearFrame(); in_frame[1] = 64'h02 << 24;
        applyStimulus(ROWS); waitIdle();
        checkOutput("ne_odd_row0", got_rows[0], 64'h02 << 32);

        clearFrame(); in_frame[1] = 64'h10 << 24;
        applyStimulus(ROWS); waitIdle();
        checkOutput("sw_odd_row2", got_rows[2], 64'h10 << 24);

        clearFrame(); in_frame[2] = 64'hC0 << 40;
        applyStimulus(ROWS); waitIdle();
        checkOutput("rest_obst_row2", got_rows[2], 64'hC0 << 40);

        clearFrame(); in_frame[0] = 64'h02 << 16;
        applyStimulus(ROWS); waitIdle();
        for (int r = 0; r < ROWS; r++) begin
`ifdef LTCPROP_BOUNCE_EN
            checkOutput($sformatf("edge_row%0d", r), got_rows[r], (r == 0) ? (64'h10 << 16) : 64'h0);
`else
            checkOutput($sformatf("edge_row%0d", r), got_rows[r], 64'h0);
`endif
        end

        $display("[TB] conservation frame");
        randomFrame(); in_frame[0] = '0; in_frame[ROWS-1] = '0;
        applyStimulus(ROWS); waitIdle();
        sum_in = 0; sum_out = 0;
        for (int r = 0; r < ROWS; r++) begin
            sum_in  += $countones(in_frame[r]);
            sum_out += $countones(got_rows[r]);
        end
        checkOutput("particle_count", 64'(sum_out), 64'(sum_in));

        $display("[TB] backpressure stall");
        ready_mode = 2;
        repeat (3) begin @(posedge clk); #1; end
        randomFrame();
        fork
            applyStimulus(ROWS);
            stallCheck();
        join
        waitIdle();

        $display("[TB] random back-to-back frames");
        ready_mode = 1;
        for (int f = 0; f < 6; f++) begin
            randomFrame();
            applyStimulus(ROWS);
        end
        waitIdle();
        ready_mode = 0;
        for (int f = 0; f < 3; f++) begin
            randomFrame();
            applyStimulus(ROWS);
        end
        waitIdle();

        $display("[TB] reset mid-frame");
        randomFrame();
        applyStimulus(3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("midreset_in_ready", {63'b0, in_ready}, 64'd1);
        exp_q.delete();
        got_idx = 0;
        @(posedge clk); #1;
        randomFrame();
        applyStimulus(ROWS); waitIdle();
        for (int r = 0; r < ROWS; r++)
            checkOutput($sformatf("post_reset_row%0d", r), got_rows[r], exp_frame[r]);
        repeat (5) begin @(posedge clk); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
